// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with a single-outstanding-request
// memory front end and redirect (flush) support.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   start_i        fetch enable; gates new memory requests only
//   redirect_i     flush the queue and restart fetching at redirect_pc_i
//   redirect_pc_i  new fetch address (bits [1:0] ignored)
//   mem_req_o      instruction-memory read request (held until mem_ack_i)
//   mem_addr_o     word-aligned request address (stable while mem_req_o=1)
//   mem_ack_i      memory returns mem_data_i this cycle
//   mem_data_i     returned instruction word
//   inst_valid_o   queue head holds an instruction
//   inst_o         queue-head instruction
//   inst_pc_o      address of inst_o
//   inst_ready_i   consumer accepts the head this cycle
//   count_o        number of occupied queue entries
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic [2:0]  count_o
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] PC_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] mem_addr_d;
  logic [CNT_W-1:0] count_q, count_d, count_pop;
  entry_t          q_q [DEPTH];
  entry_t          q_d [DEPTH];
  logic            pop, push, can_issue, issue;

  // Head of the shift-register queue is entry 0, so the outputs come
  // straight from flops with no path from mem_data_i.
  assign inst_o    = q_q[0].inst;
  assign inst_pc_o = q_q[0].pc;
  assign count_o   = count_q;

  // Next-state, fetch-pc, queue and request-address logic.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_o;
    q_d        = q_q;
    issue      = 1'b0;

    // A redirect kills both the pop and the push of its cycle.
    pop       = inst_valid_o && inst_ready_i && !redirect_i;
    push      = (state_q == REQ) && mem_ack_i && !redirect_i;
    count_pop = count_q - CNT_W'(pop);
    count_d   = redirect_i ? '0 : count_pop + CNT_W'(push);

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & PC_MASK;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end

    // Slot for the returning word is reserved at issue time.
    can_issue = start_i && (count_d < CNT_W'(DEPTH));

    case (state_q)
      IDLE: begin
        // A redirect seen in IDLE only moves fetch_pc; issue resumes next cycle.
        if (!redirect_i && can_issue) begin
          issue   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          issue   = can_issue;
          state_d = can_issue ? REQ : IDLE;
        end else if (redirect_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack_i) begin
          issue   = can_issue;
          state_d = can_issue ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      mem_addr_d = fetch_pc_d;
    end

    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        q_d[i] = q_q[i+1];
      end
    end

    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (count_pop == CNT_W'(i)) begin
          q_d[i] = '{inst: mem_data_i, pc: mem_addr_o};
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      mem_addr_o   <= '0;
      mem_req_o    <= 1'b0;
      count_q      <= '0;
      inst_valid_o <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      mem_addr_o   <= mem_addr_d;
      mem_req_o    <= (state_d != IDLE);
      count_q      <= count_d;
      inst_valid_o <= (count_d != '0);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_q[i] <= q_d[i];
      end
    end
  end

endmodule
